alu_cmd_sequencer: RTL

Command sequencer directly upstream of the 32-bit ALU. It accepts one instruction per valid/ready handshake and reads operands from an internal 8 x 32-bit register file. It drives the ALU operand and opcode inputs, captures the ALU result and flags, writes the result back, and returns a response over a second valid/ready handshake. The ALU itself stays purely combinational; all sequencing, storage and flow control live here.

---
 rtl/alu_cmd_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts one command at a time, feeds a combinational ALU from an 8x32 register file,
// writes back the result and returns it over a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int NREGS = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [2:0]       cmd_rd_i,
  input  logic [2:0]       cmd_rs_i,
  input  logic [2:0]       cmd_rt_i,
  input  logic             cmd_use_imm_i,
  input  logic [WIDTH-1:0] cmd_imm_i,
  output logic [WIDTH-1:0] alu_operand_a_o,
  output logic [WIDTH-1:0] alu_operand_b_o,
  output logic [3:0]       alu_opsel_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_overflow_i,
  input  logic             alu_equal_i,
  input  logic [1:0]       alu_carry_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_overflow_o,
  output logic             rsp_equal_o,
  output logic             rsp_illegal_o,
  output logic [1:0]       rsp_carry_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  // bit n set means opcode n is a real ALU operation
  localparam logic [15:0] LEGAL = 16'b0000_1011_1110_0110;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d, opsel_q, opsel_d;
  logic [2:0] rd_q, rd_d;
  logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, res_q, res_d;
  logic ovf_q, ovf_d, eq_q, eq_d, ill_q, ill_d;
  logic [1:0] carry_q, carry_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic legal, loadi, wb_en;
  assign legal = LEGAL[op_q];
  assign loadi = &op_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rd_d = rd_q;
    imm_d = imm_q;
    a_d = a_q;
    b_d = b_q;
    opsel_d = opsel_q;
    res_d = res_q;
    ovf_d = ovf_q;
    eq_d = eq_q;
    ill_d = ill_q;
    carry_d = carry_q;
    wb_en = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d = EXEC;
        op_d = cmd_op_i;
        rd_d = cmd_rd_i;
        imm_d = cmd_imm_i;
        a_d = regs_q[cmd_rs_i];
        b_d = cmd_use_imm_i ? cmd_imm_i : regs_q[cmd_rt_i];
        opsel_d = LEGAL[cmd_op_i] ? cmd_op_i : 4'b0000;
      end
      EXEC: begin
        state_d = RESP;
        res_d = legal ? alu_result_i : loadi ? imm_q : '0;
        ovf_d = legal & alu_overflow_i;
        eq_d = legal & alu_equal_i;
        carry_d = legal ? alu_carry_i : 2'b00;
        ill_d = !(legal || loadi || op_q == 4'b0000);
        wb_en = (legal || loadi) && rd_q != 3'd0;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      imm_q <= '0;
      a_q <= '0;
      b_q <= '0;
      opsel_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      eq_q <= 1'b0;
      ill_q <= 1'b0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      imm_q <= imm_d;
      a_q <= a_d;
      b_q <= b_d;
      opsel_q <= opsel_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      eq_q <= eq_d;
      ill_q <= ill_d;
      carry_q <= carry_d;
    end
  end
  // r0 is never written, so it always reads as zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[rd_q] <= res_d;
    end
  end
  assign cmd_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign alu_operand_a_o = a_q;
  assign alu_operand_b_o = b_q;
  assign alu_opsel_o = opsel_q;
  assign rsp_result_o = res_q;
  assign rsp_overflow_o = ovf_q;
  assign rsp_equal_o = eq_q;
  assign rsp_illegal_o = ill_q;
  assign rsp_carry_o = carry_q;
endmodule
